// File: rtl/hps_st_arb_pkg.sv
// Shared types for the packet-aware byte-stream arbiter and its output skid buffer.
// Optional macro HPS_ST_ARB_CHANNEL_EN adds a per-beat source channel field.
package hps_st_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int SKID_DEPTH = 2;
  localparam int CNT_W      = $clog2(SKID_DEPTH + 1);
  // Wide enough for the largest supported requester count (8).
  localparam int CH_W       = 3;

  typedef struct packed {
    logic [7:0]      data;
    logic            sop;
    logic            eop;
`ifdef HPS_ST_ARB_CHANNEL_EN
    logic [CH_W-1:0] channel;
`endif
  } beat_t;

endpackage

// File: rtl/hps_st_byte_arbiter_if.sv
// Avalon-ST bundle: NUM_REQ requester byte streams in, one arbitrated byte stream out.
// With HPS_ST_ARB_CHANNEL_EN defined the output also carries out_channel.
interface hps_st_byte_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]   in_valid;
  logic [8*NUM_REQ-1:0] in_data;
  logic [NUM_REQ-1:0]   in_startofpacket;
  logic [NUM_REQ-1:0]   in_endofpacket;
  logic [NUM_REQ-1:0]   in_ready;
  logic                 out_valid;
  logic [7:0]           out_data;
  logic                 out_startofpacket;
  logic                 out_endofpacket;
  logic                 out_ready;
`ifdef HPS_ST_ARB_CHANNEL_EN
  logic [IDX_W-1:0]     out_channel;
`endif

  // Environment side: drives the requesters and sinks the output stream.
  modport master (
    output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
`ifdef HPS_ST_ARB_CHANNEL_EN
    input  out_channel,
`endif
    input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket
  );

  // Arbiter side.
  modport slave (
    input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
`ifdef HPS_ST_ARB_CHANNEL_EN
    output out_channel,
`endif
    output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket
  );

endinterface

// File: rtl/hps_st_skid_buf.sv
// Two-entry FIFO holding arbitrated beats; the head entry drives the output stream.
// Beat width follows beat_t, which grows when HPS_ST_ARB_CHANNEL_EN is defined.
module hps_st_skid_buf
  import hps_st_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  beat_t            push_beat,
  input  logic             pop,
  output beat_t            head,
  output logic [CNT_W-1:0] count
);

  beat_t mem [SKID_DEPTH];
  logic  wr_ptr;
  logic  rd_ptr;
  logic  do_push;
  logic  do_pop;

  assign do_push = push & (count != CNT_W'(SKID_DEPTH));
  assign do_pop  = pop & (count != '0);

  // Storage is cleared too so the idle output bus reads zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/hps_st_byte_arbiter.sv
// Packet-locked round-robin arbiter sharing one Avalon-ST byte channel among NUM_REQ sources.
// Define HPS_ST_ARB_CHANNEL_EN to expose the source index of each beat on out_channel.
module hps_st_byte_arbiter
  import hps_st_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  hps_st_byte_arbiter_if.slave st,
  output logic [NUM_REQ-1:0]  grant,
  output logic                busy
);

  arb_state_e         state;
  arb_state_e         state_nxt;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   gidx_nxt;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   last_nxt;
  logic [IDX_W:0]     cand;
  logic               found;
  logic [IDX_W-1:0]   scan_idx;
  logic [NUM_REQ-1:0] ready_vec;
  logic               push;
  logic               pop;
  beat_t              push_beat;
  beat_t              head;
  logic [CNT_W-1:0]   count;

  // Round-robin scan starting just after the last winner, wrapping at NUM_REQ.
  always_comb begin
    found    = 1'b0;
    scan_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, last} + (IDX_W+1)'(k + 1);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && st.in_valid[cand[IDX_W-1:0]]) begin
        found    = 1'b1;
        scan_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Ready comes from the registered fill level only, keeping out_ready off this path.
  always_comb begin
    state_nxt = state;
    gidx_nxt  = gidx;
    last_nxt  = last;
    ready_vec = '0;
    push      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (found) begin
          state_nxt = ARB_LOCKED;
          gidx_nxt  = scan_idx;
          last_nxt  = scan_idx;
        end
      end
      ARB_LOCKED: begin
        ready_vec[gidx] = (count < CNT_W'(SKID_DEPTH));
        push            = st.in_valid[gidx] & ready_vec[gidx];
        if (push && st.in_endofpacket[gidx]) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      gidx  <= '0;
      last  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      gidx  <= gidx_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    push_beat      = '0;
    push_beat.data = st.in_data[{gidx, 3'b000} +: 8];
    push_beat.sop  = st.in_startofpacket[gidx];
    push_beat.eop  = st.in_endofpacket[gidx];
`ifdef HPS_ST_ARB_CHANNEL_EN
    push_beat.channel = CH_W'(gidx);
`endif
  end

  assign pop = st.out_valid & st.out_ready;

  hps_st_skid_buf u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign st.in_ready          = ready_vec;
  assign st.out_valid         = (count != '0);
  assign st.out_data          = head.data;
  assign st.out_startofpacket = head.sop;
  assign st.out_endofpacket   = head.eop;
`ifdef HPS_ST_ARB_CHANNEL_EN
  assign st.out_channel       = IDX_W'(head.channel);
`endif

  assign grant = (state == ARB_LOCKED) ? (NUM_REQ'(1) << gidx) : '0;
  assign busy  = (state == ARB_LOCKED) | (count != '0);

endmodule

// File: tb/tb_hps_st_byte_arbiter.sv
// Bench for hps_st_byte_arbiter: directed vector tables, reset-mid-packet sequence,
// and randomized traffic checked against a queue-based packet model.
module tb_hps_st_byte_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hps_st_byte_arbiter_if #(.NUM_REQ(N)) bus ();
  logic [N-1:0] grant;
  logic         busy;

  hps_st_byte_arbiter #(.NUM_REQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .st    (bus),
    .grant (grant),
    .busy  (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] s,
                       input logic [3:0] e, input bit o);
    bus.in_valid         = v;
    bus.in_data          = d;
    bus.in_startofpacket = s;
    bus.in_endofpacket   = e;
    bus.out_ready        = o;
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] vld;
    logic [31:0] d;
    logic [3:0] s, e;
    bit         ordy, chk;
    logic [3:0] eg, er;
    bit         eov;
    logic [7:0] eod;
    bit         eos, eoe;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, logic [3:0] vld, logic [31:0] d, logic [3:0] s,
                              logic [3:0] e, bit ordy, bit chk, logic [3:0] eg,
                              logic [3:0] er, bit eov, logic [7:0] eod, bit eos, bit eoe);
    vec_t v;
    v.rst = rst; v.vld = vld; v.d = d; v.s = s; v.e = e; v.ordy = ordy; v.chk = chk;
    v.eg = eg; v.er = er; v.eov = eov; v.eod = eod; v.eos = eos; v.eoe = eoe;
    return v;
  endfunction

  // Reference model state: per-source beat queues and in-flight output beats.
  typedef struct {
    logic [7:0] d;
    bit         s, e;
    int         ch;
  } tb_beat_t;

  tb_beat_t srcq[N][$];
  tb_beat_t mq[$];
  int       glog[$];

  task automatic fill(input bit two_byte);
    for (int i = 0; i < N; i++) begin
      int npk;
      srcq[i].delete();
      npk = two_byte ? 2 : $urandom_range(2, 5);
      for (int p = 0; p < npk; p++) begin
        int len;
        len = two_byte ? 2 : $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          tb_beat_t bt;
          bt.d  = 8'($urandom);
          bt.s  = (b == 0);
          bt.e  = (b == len - 1);
          bt.ch = i;
          srcq[i].push_back(bt);
        end
      end
    end
  endtask

  task automatic run_model(input int min_cyc, input int pv, input int po);
    bit  mlock = 1'b0;
    int  mg = 0;
    int  mlast = N - 1;
    bit  cur[N];
    int  cyc = 0;
    bit  done = 1'b0;
    int  remain;
    mq.delete();
    glog.delete();
    for (int i = 0; i < N; i++) cur[i] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(4'h0, 32'h0, 4'h0, 4'h0, 1'b1);
    while (!done) begin
      logic [3:0]  v, s, e, eg, er;
      logic [31:0] d;
      bit          o, eov, mpush, mpop, fnd;
      tb_beat_t    pb;
      int          epv, epo;
      @(negedge clk);
      reset = 1'b0;
      epv = (cyc >= min_cyc) ? 100 : pv;
      epo = (cyc >= min_cyc) ? 100 : po;
      v = '0; s = '0; e = '0; d = '0;
      for (int i = 0; i < N; i++) begin
        if (!cur[i] && srcq[i].size() > 0 && $urandom_range(0, 99) < epv) cur[i] = 1'b1;
        if (cur[i]) begin
          v[i]        = 1'b1;
          d[8*i +: 8] = srcq[i][0].d;
          s[i]        = srcq[i][0].s;
          e[i]        = srcq[i][0].e;
        end
      end
      o = ($urandom_range(0, 99) < epo);
      drive(v, d, s, e, o);
      #1;
      eg  = mlock ? 4'(1 << mg) : 4'h0;
      er  = (mlock && mq.size() < 2) ? 4'(1 << mg) : 4'h0;
      eov = (mq.size() != 0);
      check("rand_ctl", 64'({grant, bus.in_ready, bus.out_valid}), 64'({eg, er, eov}));
      if (eov) begin
        check("rand_beat", 64'({bus.out_data, bus.out_startofpacket, bus.out_endofpacket}),
              64'({mq[0].d, mq[0].s, mq[0].e}));
`ifdef HPS_ST_ARB_CHANNEL_EN
        check("rand_chan", 64'(bus.out_channel), 64'(mq[0].ch));
`endif
      end
      // Model transition for the coming edge.
      mpop  = eov && o;
      mpush = mlock && (mq.size() < 2) && cur[mg];
      if (mpush) pb = srcq[mg][0];
      if (mpop) void'(mq.pop_front());
      if (mpush) mq.push_back(pb);
      if (mpush && pb.e) begin
        mlock = 1'b0;
      end else if (!mlock) begin
        fnd = 1'b0;
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (mlast + k) % N;
          if (!fnd && cur[idx]) begin
            fnd   = 1'b1;
            mlock = 1'b1;
            mg    = idx;
            mlast = idx;
            glog.push_back(idx);
          end
        end
      end
      // Source driver follows the handshake seen on the bus.
      for (int i = 0; i < N; i++) begin
        if (v[i] && bus.in_ready[i]) begin
          void'(srcq[i].pop_front());
          cur[i] = 1'b0;
        end
      end
      cyc++;
      remain = mq.size();
      for (int i = 0; i < N; i++) remain += srcq[i].size();
      if (remain == 0 && !mlock) done = 1'b1;
      if (cyc > min_cyc + 2000) done = 1'b1;
    end
    check("rand_drained", 64'(remain), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    drive(4'h0, 32'h0, 4'h0, 4'h0, 1'b1);
    reset = 1'b1;

    // Single requester, 3-byte packet.
    tbl.push_back(mk(0, 4'b0001, 32'h11, 4'b0001, 4'b0000, 1, 1, 4'h0, 4'h0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 32'h11, 4'b0001, 4'b0000, 1, 1, 4'h1, 4'h1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 32'h22, 4'b0000, 4'b0000, 1, 1, 4'h1, 4'h1, 1, 8'h11, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 32'h33, 4'b0000, 4'b0001, 1, 1, 4'h1, 4'h1, 1, 8'h22, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 32'h00, 4'b0000, 4'b0000, 1, 1, 4'h0, 4'h0, 1, 8'h33, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 32'h00, 4'b0000, 4'b0000, 1, 1, 4'h0, 4'h0, 0, 8'h00, 0, 0));
    // Backpressure: out_ready low for 5 cycles while 0x22 sits at the head.
    tbl.push_back(mk(1, 4'b0000, 32'h00, 4'b0000, 4'b0000, 1, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 32'h11, 4'b0001, 4'b0000, 1, 1, 4'h0, 4'h0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 32'h11, 4'b0001, 4'b0000, 1, 1, 4'h1, 4'h1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 32'h22, 4'b0000, 4'b0000, 1, 1, 4'h1, 4'h1, 1, 8'h11, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 32'h33, 4'b0000, 4'b0000, 0, 1, 4'h1, 4'h1, 1, 8'h22, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 4'b0001, 32'h44, 4'b0000, 4'b0001, 0, 1, 4'h1, 4'h0, 1, 8'h22, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 32'h44, 4'b0000, 4'b0001, 1, 1, 4'h1, 4'h0, 1, 8'h22, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 32'h44, 4'b0000, 4'b0001, 1, 1, 4'h1, 4'h1, 1, 8'h33, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 32'h00, 4'b0000, 4'b0000, 1, 1, 4'h0, 4'h0, 1, 8'h44, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 32'h00, 4'b0000, 4'b0000, 1, 1, 4'h0, 4'h0, 0, 8'h00, 0, 0));
    // Single-beat packets on req1 (0xA5) and req2 (0x5A).
    tbl.push_back(mk(1, 4'b0000, 32'h00, 4'b0000, 4'b0000, 1, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0110, 32'h005A_A500, 4'b0110, 4'b0110, 1, 1, 4'h0, 4'h0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0110, 32'h005A_A500, 4'b0110, 4'b0110, 1, 1, 4'h2, 4'h2, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 32'h005A_0000, 4'b0100, 4'b0100, 1, 1, 4'h0, 4'h0, 1, 8'hA5, 1, 1));
    tbl.push_back(mk(0, 4'b0100, 32'h005A_0000, 4'b0100, 4'b0100, 1, 1, 4'h4, 4'h4, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 32'h00, 4'b0000, 4'b0000, 1, 1, 4'h0, 4'h0, 1, 8'h5A, 1, 1));
    tbl.push_back(mk(0, 4'b0000, 32'h00, 4'b0000, 4'b0000, 1, 1, 4'h0, 4'h0, 0, 8'h00, 0, 0));

    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 64'({grant, bus.in_ready, bus.out_valid, bus.out_data,
                              bus.out_startofpacket, bus.out_endofpacket, busy}), 64'(0));

    foreach (tbl[r]) begin
      @(negedge clk);
      reset = tbl[r].rst;
      drive(tbl[r].vld, tbl[r].d, tbl[r].s, tbl[r].e, tbl[r].ordy);
      #1;
      if (tbl[r].chk) begin
        check($sformatf("tbl%0d_ctl", r), 64'({grant, bus.in_ready, bus.out_valid}),
              64'({tbl[r].eg, tbl[r].er, tbl[r].eov}));
        if (tbl[r].eov)
          check($sformatf("tbl%0d_beat", r),
                64'({bus.out_data, bus.out_startofpacket, bus.out_endofpacket}),
                64'({tbl[r].eod, tbl[r].eos, tbl[r].eoe}));
      end
    end

    // Reset after two of four bytes of a req0 packet.
    @(negedge clk); reset = 1'b0; drive(4'b0001, 32'h11, 4'b0001, 4'b0000, 1'b1);
    @(negedge clk); drive(4'b0001, 32'h11, 4'b0001, 4'b0000, 1'b1);
    @(negedge clk); drive(4'b0001, 32'h22, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk); drive(4'b0001, 32'h33, 4'b0000, 4'b0000, 1'b1);
    #1;
    check("pre_rst", 64'({grant, busy, bus.out_valid, bus.out_data}), 64'({4'h1, 1'b1, 1'b1, 8'h22}));
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; drive(4'b0101, 32'h00BB_0011, 4'b0101, 4'b0000, 1'b1);
    #1;
    check("rst_flush", 64'({grant, bus.in_ready, busy, bus.out_valid, bus.out_data,
                            bus.out_startofpacket, bus.out_endofpacket}), 64'(0));
    @(negedge clk);
    #1;
    check("rst_prio", 64'(grant), 64'(4'b0001));

    // Round-robin with all requesters continuously valid, 2-byte packets.
    fill(1'b1);
    run_model(0, 100, 100);
    check("rr_count", 64'(glog.size()), 64'(8));
    for (int k = 0; k < glog.size() && k < 8; k++)
      check($sformatf("rr_order%0d", k), 64'(glog[k]), 64'(k % N));

    // Randomized traffic with valid gaps and downstream backpressure.
    fill(1'b0);
    run_model(300, 60, 60);
    fill(1'b0);
    run_model(300, 30, 85);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
